nestedfor_pair_streamer: RTL and testbench
==========================================

// Module: nestedfor_pair_streamer
// PURPOSE
//  Downstream consumer of the nested-for pair FIFO (FIFO_nestedfor). Drives its re input under credit
//  control and qualifies its valid_out/dout (valid_out holds while re is low). Buffers pairs in a local FIFO.
//  Re-issues them as a ready/valid stream with m_last on the final pair, a pair count and a done pulse.
// PARAMETERS
//  DW     8      element width; a pair is 2*DW bits
//  AW     8      upstream address width; at most 2**AW elements
//  DEPTH  4      local pair FIFO entries; power of 2, >=2
//  CW     2*AW   pair_count width; holds N*(N-1)/2
// PORTS
//  clk        in   1       clock
//  rst        in   1       synchronous, active-high reset
//  start      in   1       pulse: begin consuming a pair stream (ignored unless IDLE)
//  up_re      out  1       read enable to upstream nested-for FIFO
//  up_valid   in   1       upstream valid_out
//  up_pair    in   2*DW    upstream dout; [DW-1:0]=first elem, [2DW-1:DW]=second elem
//  m_valid    out  1       output pair valid
//  m_ready    in   1       output pair accepted when m_valid&&m_ready
//  m_data     out  2*DW    output pair, same packing as up_pair
//  m_last     out  1       qualifies m_data as the final pair of the stream
//  busy       out  1       state != IDLE
//  done       out  1       one-cycle pulse at end of stream
//  pair_count out  CW      pairs accepted this stream; cleared on start
// BEHAVIOUR
//  Reset: state=IDLE, up_re=0, re_q=0, FIFO empty, m_valid=0, m_last=0, done=0, pair_count=0.
//  Upstream contract: up_re high in cycle t -> up_valid/up_pair meaningful in cycle t+1. re_q = up_re delayed 1.
//  Accept: push up_pair iff re_q && up_valid. up_valid with re_q=0 is stale -> ignored (no duplicates).
//  End detect: re_q && !up_valid. Covers 0-pair streams (N<2 elements).
//  Credit: up_re = (state==RUN) && (occ + re_q < DEPTH). Pops are ignored, so the FIFO never overflows.
//  FSM:
//   IDLE  -start-> RUN; clears pair_count
//   RUN   -end detect-> DRAIN; up_re forced 0 the same cycle
//   DRAIN -occ==0 (incl. immediately)-> DONE
//   DONE  -> IDLE; done=1 for this cycle only
//  Tail hold: in RUN the newest entry may be last, so m_valid = (occ>=2). In DRAIN, m_valid = (occ>=1).
//  m_last = (state==DRAIN) && (occ==1). m_data = FIFO head. Holds stable while m_valid && !m_ready.
//  Simultaneous push+pop in the same cycle: occ unchanged. Pointers wrap mod DEPTH.
//  pair_count increments per accepted push. It holds after done until the next start.
//  start while busy: ignored. rst mid-stream: immediate return to reset state; buffered pairs are discarded.
//  Upstream must be reset/reloaded by its owner.
//  Latency: first pair is accepted 1 cycle after the first up_re. A lone final pair appears on m_* 1 cycle after end detect.
// STRUCTURE
//  nestedfor_pkg: state encoding (IDLE/RUN/DRAIN/DONE) and pair width localparam PW=2*DW.
//  Sub-module pair_sync_fifo #(PW,DEPTH): registered-pointer sync FIFO with occ output, push, pop and head data.
//  Top level: FSM, credit logic, re_q, tail-hold/m_last, pair_count.
// TESTING
//  1 Write A1..A4 upstream, start, m_ready=1 -> m_data = {A2,A1},{A3,A1},{A4,A1},{A3,A2},{A4,A2},{A4,A3}.
//    m_last only on {A4,A3}; done 1 cycle later; pair_count=6.
//  2 Same load, m_ready=0 for 12 cycles, DEPTH=4 -> up_re drops with occ=4.
//    After release, same 6 pairs, no loss or duplicate.
//  3 N=2 (B1,B2) -> single beat {B2,B1} with m_last=1; count=1.
//    N=1 -> no m_valid; done pulses; count=0.
//  4 Random m_ready toggling, N=8 -> 28 pairs in lexicographic order; exactly one m_last; count=28.
//  5 rst asserted in RUN after 3 pairs -> next cycle up_re=0, m_valid=0, count=0, busy=0.
//    start pulse while busy -> ignored; stream unaffected.

Source files
------------

// File: rtl/nestedfor_pair_streamer_pkg.sv
// Shared types and defaults for the nested-for pair streamer.
// The FSM state encoding and the pair-width helper live here.
package nestedfor_pair_streamer_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   localparam int unsigned DW = 8;
   localparam int unsigned PW = 2 * DW;

   function automatic int unsigned pair_width(input int unsigned dw);
      return 2 * dw;
   endfunction

endpackage

// File: rtl/nestedfor_pair_streamer_if.sv
// Upstream read port and downstream ready/valid pair stream of the streamer.
// The master modport is the streamer side.
interface nestedfor_pair_streamer_if #(
   parameter int unsigned DW = 8
);
   logic            up_re;
   logic            up_valid;
   logic [2*DW-1:0] up_pair;
   logic            m_valid;
   logic            m_ready;
   logic [2*DW-1:0] m_data;
   logic            m_last;

   modport master (
      output up_re, m_valid, m_data, m_last,
      input  up_valid, up_pair, m_ready
   );

   modport slave (
      input  up_re, m_valid, m_data, m_last,
      output up_valid, up_pair, m_ready
   );
endinterface

// File: rtl/nestedfor_pair_streamer_fifo.sv
// Registered-pointer synchronous FIFO holding pairs, with occupancy output.
// Push when full and pop when empty are dropped.
module pair_sync_fifo #(
   parameter int unsigned PW    = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [PW-1:0]            wdata,
   output logic [PW-1:0]            rdata,
   output logic [$clog2(DEPTH):0]   occ
);
   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]     occ_q, occ_d;
   logic [PW-1:0]     mem_q [DEPTH];
   logic [PW-1:0]     mem_d [DEPTH];
   logic              do_push, do_pop;

   always_comb begin
      do_push  = push && (occ_q != (PtrW+1)'(DEPTH));
      do_pop   = pop && (occ_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      mem_d    = mem_q;
      // Power-of-2 depth lets the pointers wrap by plain overflow.
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      occ_d = occ_q + (PtrW+1)'(1);
      else if (!do_push && do_pop) occ_d = occ_q - (PtrW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign occ   = occ_q;
endmodule

// File: rtl/nestedfor_pair_streamer.sv
// Consumes pairs from the upstream nested-for FIFO under credit control and
// re-issues them as a ready/valid stream with a last marker, count and done pulse.
module nestedfor_pair_streamer
   import nestedfor_pair_streamer_pkg::*;
#(
   parameter int unsigned DW    = 8,
   parameter int unsigned AW    = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = 2 * AW
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   nestedfor_pair_streamer_if.master    bus,
   output logic                         busy,
   output logic                         done,
   output logic [CW-1:0]                pair_count
);
   localparam int unsigned PairW = pair_width(DW);
   localparam int unsigned OccW  = $clog2(DEPTH) + 1;

   state_e          state_q, state_d;
   logic            re_q, re_d;
   logic [CW-1:0]   count_q, count_d;
   logic [OccW-1:0] occ;
   logic [PairW-1:0] head;
   logic            push, pop, end_det;
   logic            up_re, m_valid, m_last;

   pair_sync_fifo #(
      .PW    (PairW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (bus.up_pair),
      .rdata (head),
      .occ   (occ)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      up_re   = 1'b0;
      m_valid = 1'b0;
      m_last  = 1'b0;
      done    = 1'b0;
      // up_valid is only fresh the cycle after a read; otherwise it is a held copy.
      push    = (state_q == StRun) && re_q && bus.up_valid;
      end_det = (state_q == StRun) && re_q && !bus.up_valid;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               count_d = '0;
            end
         end
         StRun: begin
            // The newest entry might be the final pair, so hold it back.
            m_valid = (occ >= OccW'(2));
            if (end_det) state_d = StDrain;
            else         up_re   = (int'(occ) + int'(re_q)) < int'(DEPTH);
         end
         StDrain: begin
            m_valid = (occ != '0);
            m_last  = (occ == OccW'(1));
            if (occ == '0) state_d = StDone;
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (push) count_d = count_q + CW'(1);
      re_d = up_re;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         re_q    <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         re_q    <= re_d;
         count_q <= count_d;
      end
   end

   assign pop         = m_valid && bus.m_ready;
   assign bus.up_re   = up_re;
   assign bus.m_valid = m_valid;
   assign bus.m_last  = m_last;
   assign bus.m_data  = head;
   assign busy        = (state_q != StIdle);
   assign pair_count  = count_q;
endmodule

// File: tb/tb_nestedfor_pair_streamer.sv
// Scoreboard bench: an upstream nested-for FIFO model feeds the streamer while a
// monitor pops expected pairs whenever a beat is accepted.
module tb_nestedfor_pair_streamer;
   localparam int unsigned DW = 8, AW = 8, DEPTH = 4, CW = 16, PW = 16;

   logic          clk = 1'b0;
   logic          rst, start;
   logic          busy, done;
   logic [CW-1:0] pair_count;

   nestedfor_pair_streamer_if #(.DW(DW)) bus ();

   nestedfor_pair_streamer #(
      .DW    (DW),
      .AW    (AW),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bus        (bus),
      .busy       (busy),
      .done       (done),
      .pair_count (pair_count)
   );

   always #5 clk = ~clk;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [PW:0]   exp_q[$];
   logic [PW-1:0] up_pairs[$];
   int            up_idx = 0;
   bit            rnd_ready = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Loads the upstream model with n elements and queues the expected pairs.
   task automatic load(input int n, input logic [DW-1:0] base);
      logic [DW-1:0] el[$];
      logic [PW-1:0] p;
      int total, k;
      el.delete();
      up_pairs.delete();
      for (int i = 0; i < n; i++) el.push_back(base + DW'(i * 7));
      total = (n * (n - 1)) / 2;
      k = 0;
      for (int i = 0; i < n; i++)
         for (int j = i + 1; j < n; j++) begin
            p = {el[j], el[i]};
            up_pairs.push_back(p);
            k++;
            exp_q.push_back({(k == total) ? 1'b1 : 1'b0, p});
         end
      up_idx = 0;
      bus.up_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int bound, input int exp_cnt);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < bound && !seen; c++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check({name, " done_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         check({name, " pair_count"}, 32'(pair_count), 32'(exp_cnt));
         check({name, " all_pairs_out"}, 32'(exp_q.size()), 32'd0);
         @(negedge clk);
         check({name, " done_one_cycle"}, 32'(done), 32'd0);
         check({name, " idle_after"}, 32'(busy), 32'd0);
      end
   endtask

   // Upstream model: a read in cycle t presents the next pair (or valid low) in t+1.
   initial begin
      bit re_s;
      bus.up_valid = 1'b0;
      bus.up_pair  = '0;
      forever begin
         @(negedge clk);
         re_s = bus.up_re;
         @(posedge clk);
         #1;
         if (re_s) begin
            if (up_idx < up_pairs.size()) begin
               bus.up_valid = 1'b1;
               bus.up_pair  = up_pairs[up_idx];
               up_idx++;
            end else begin
               bus.up_valid = 1'b0;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rnd_ready) begin
         #1;
         bus.m_ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: every accepted beat must match the head of the expected queue.
   always @(negedge clk) begin
      if (!rst && bus.m_valid && bus.m_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: got %0h expected none", {bus.m_last, bus.m_data});
         end else begin
            check("beat {last,data}", 32'({bus.m_last, bus.m_data}), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      bit hit;
      rst = 1'b1;
      start = 1'b0;
      bus.m_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check("reset up_re", 32'(bus.up_re), 32'd0);
      check("reset m_valid", 32'(bus.m_valid), 32'd0);
      check("reset m_last", 32'(bus.m_last), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset count", 32'(pair_count), 32'd0);

      // N=4, ready always high.
      tick();
      load(4, 8'h11);
      bus.m_ready = 1'b1;
      pulse_start();
      wait_done("t1", 200, 6);

      // N=4 with a 12-cycle backpressure stall.
      tick();
      load(4, 8'h40);
      bus.m_ready = 1'b0;
      pulse_start();
      repeat (12) tick();
      @(negedge clk);
      check("t2 credit up_re", 32'(bus.up_re), 32'd0);
      check("t2 fifo full count", 32'(pair_count), 32'd4);
      check("t2 m_valid stalled", 32'(bus.m_valid), 32'd1);
      tick();
      bus.m_ready = 1'b1;
      wait_done("t2", 200, 6);

      // N=2: single beat marked last.
      tick();
      load(2, 8'hB1);
      pulse_start();
      wait_done("t3a", 100, 1);

      // N=1: no pairs at all.
      tick();
      load(1, 8'hC0);
      pulse_start();
      wait_done("t3b", 100, 0);

      // N=8 with random ready.
      tick();
      load(8, 8'h03);
      rnd_ready = 1'b1;
      pulse_start();
      wait_done("t4", 2000, 28);
      rnd_ready = 1'b0;
      tick();
      bus.m_ready = 1'b1;

      // Reset mid-stream after 3 pairs accepted.
      tick();
      load(8, 8'h60);
      bus.m_ready = 1'b0;
      pulse_start();
      hit = 1'b0;
      for (int c = 0; c < 60 && !hit; c++) begin
         @(negedge clk);
         if (pair_count == CW'(3)) hit = 1'b1;
      end
      check("t5 reached 3 pairs", 32'(hit), 32'd1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("t5 up_re", 32'(bus.up_re), 32'd0);
      check("t5 m_valid", 32'(bus.m_valid), 32'd0);
      check("t5 count", 32'(pair_count), 32'd0);
      check("t5 busy", 32'(busy), 32'd0);

      // Start while busy is ignored.
      tick();
      load(4, 8'h21);
      bus.m_ready = 1'b1;
      pulse_start();
      tick();
      pulse_start();
      wait_done("t5b", 200, 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
